// File: rtl/bitpack_pkg.sv
// Shared types and constants for the bitpack stochastic datapath.
// Holds the generator FSM states and the Galois LFSR step function.
package bitpack_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } sn_state_t;

    localparam int          SN_WIDTH = 16;
    localparam logic [15:0] SN_SEED  = 16'hACE1;
    localparam logic [15:0] SN_TAPS  = 16'hB400;

    // One right-shifting Galois step; callers narrow the result to their width.
    function automatic logic [31:0] lfsr_next(
        input logic [31:0] state,
        input logic [31:0] taps
    );
        return state[0] ? ((state >> 1) ^ taps) : (state >> 1);
    endfunction

endpackage

// File: rtl/sn_generator_lfsr.sv
// Galois LFSR used as the random source of the stochastic-number generator.
// Load restarts the sequence from the seed; a zero seed is replaced by 1.
module sn_lfsr
    import bitpack_pkg::*;
#(
    parameter int               WIDTH = SN_WIDTH,
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(SN_SEED),
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(SN_TAPS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    output logic [WIDTH-1:0] state
);

    localparam logic [WIDTH-1:0] SEED_SAFE =
        (SEED == '0) ? WIDTH'(1) : SEED;

    // LFSR state: reseed on load, otherwise advance one step when asked.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SEED_SAFE;
        end else if (load) begin
            state <= SEED_SAFE;
        end else if (step) begin
            state <= WIDTH'(lfsr_next(32'(state), 32'(TAPS)));
        end
    end

endmodule

// File: rtl/sn_generator.sv
// Stochastic-number generator: signed value in, ternary P/N bitstream out.
// Stream length is programmable; EN_OUT marks each valid element.
module sn_generator
    import bitpack_pkg::*;
#(
    parameter int               WIDTH     = SN_WIDTH,
    parameter logic [WIDTH-1:0] LFSR_SEED = WIDTH'(SN_SEED),
    parameter logic [WIDTH-1:0] LFSR_TAPS = WIDTH'(SN_TAPS)
) (
    input  logic        CLK,
    input  logic        RST_X,
    input  logic [31:0] DATA_IN,
    input  logic        DATA_WE,
    input  logic        LEN_WE,
    input  logic        START,
    output logic        SN_OUT_P,
    output logic        SN_OUT_N,
    output logic        EN_OUT,
    output logic        BUSY,
    output logic        DONE
);

    sn_state_t        state;
    sn_state_t        state_next;
    logic [WIDTH:0]   value;
    logic [31:0]      length;
    logic [31:0]      remaining;
    logic [WIDTH-1:0] rnd;
    logic [WIDTH:0]   mag;
    logic             sign;
    logic             hit;
    logic             run;
    logic             start_ok;

    assign start_ok = START && (state == IDLE);
    assign run      = (state == RUN);
    assign sign     = value[WIDTH];
    // Negating -2^WIDTH wraps to itself, which reads as 2^WIDTH unsigned.
    assign mag      = sign ? -value : value;
    assign hit      = {1'b0, rnd} < mag;

    sn_lfsr #(
        .WIDTH (WIDTH),
        .SEED  (LFSR_SEED),
        .TAPS  (LFSR_TAPS)
    ) u_lfsr (
        .clk   (CLK),
        .rst_n (RST_X),
        .load  (start_ok),
        .step  (run),
        .state (rnd)
    );

    // Value and length registers written from the CPU interface.
    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            value  <= '0;
            length <= '0;
        end else begin
            if (DATA_WE) begin
                value <= DATA_IN[WIDTH:0];
            end
            if (LEN_WE) begin
                length <= DATA_IN;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; START is only honoured in IDLE.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (START) begin
                    state_next = (length != '0) ? RUN : FIN;
                end
            end
            RUN: begin
                if (remaining <= 32'd1) begin
                    state_next = FIN;
                end
            end
            FIN: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Remaining-element counter; saturates at zero instead of wrapping.
    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            remaining <= '0;
        end else if (start_ok) begin
            remaining <= length;
        end else if (run && (remaining != '0)) begin
            remaining <= remaining - 32'd1;
        end
    end

    // Registered stream outputs and status flags.
    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            SN_OUT_P <= 1'b0;
            SN_OUT_N <= 1'b0;
            EN_OUT   <= 1'b0;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
        end else begin
            SN_OUT_P <= run && hit && !sign;
            SN_OUT_N <= run && hit && sign;
            EN_OUT   <= run;
            BUSY     <= (state_next != IDLE);
            DONE     <= (state == FIN);
        end
    end

endmodule
